lc3_operand_fetch: RTL and testbench

- Decode/operand-fetch stage for the LC-3 core.
- Accepts one 16-bit instruction per handshake, drives the two register-file read addresses, and captures the operand data one cycle later.
- Forwards concurrent writebacks so operands are never stale, then presents decoded operands to the execute stage through a valid/ready handshake.
- Sits between fetch (upstream) and execute (downstream); the register file's 1-cycle registered read is the timing anchor.

---
 rtl/lc3_pkg.sv | 46 ++++
 rtl/lc3_imm_decode.sv | 78 +++++++
 rtl/lc3_operand_fetch.sv | 179 +++++++++++++++++
 tb/tb_lc3_operand_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the decode/operand-fetch stage: widths, opcodes,
// FSM states and source-register helpers.
package lc3_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_BR   = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_LD   = 4'b0010;
    localparam logic [OP_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OP_W-1:0] OP_JSR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LDR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_STR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_RTI  = 4'b1000;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1001;
    localparam logic [OP_W-1:0] OP_LDI  = 4'b1010;
    localparam logic [OP_W-1:0] OP_STI  = 4'b1011;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OP_W-1:0] OP_RES  = 4'b1101;
    localparam logic [OP_W-1:0] OP_LEA  = 4'b1110;
    localparam logic [OP_W-1:0] OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StValid = 2'd2
    } state_t;

    function automatic logic [REG_AW-1:0] src1_of(input logic [DATA_W-1:0] instr);
        return instr[8:6];
    endfunction

    // Stores read their data register through port 2.
    function automatic logic [REG_AW-1:0] src2_of(input logic [DATA_W-1:0] instr);
        logic [OP_W-1:0] op;
        op = instr[15:12];
        if (op == OP_ST || op == OP_STI || op == OP_STR) begin
            return instr[11:9];
        end
        return instr[2:0];
    endfunction

endpackage

// File: rtl/lc3_imm_decode.sv
// Combinational LC-3 instruction field decode: immediate, destination and
// control flags consumed by the execute stage.
module lc3_imm_decode
    import lc3_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic [15:0] o_imm,
    output logic [2:0]  o_dst,
    output logic        o_wr_dst,
    output logic        o_set_cc,
    output logic        o_use_imm,
    output logic        o_illegal
);

    logic [3:0] w_op;

    assign w_op = i_instr[15:12];

    always_comb begin
        o_imm     = '0;
        o_dst     = i_instr[11:9];
        o_wr_dst  = 1'b0;
        o_set_cc  = 1'b0;
        o_use_imm = 1'b0;
        o_illegal = 1'b0;
        case (w_op)
            OP_ADD, OP_AND: begin
                o_imm     = {{11{i_instr[4]}}, i_instr[4:0]};
                o_use_imm = i_instr[5];
                o_wr_dst  = 1'b1;
                o_set_cc  = 1'b1;
            end
            OP_NOT: begin
                o_wr_dst = 1'b1;
                o_set_cc = 1'b1;
            end
            OP_LD, OP_LDI: begin
                o_imm    = {{7{i_instr[8]}}, i_instr[8:0]};
                o_wr_dst = 1'b1;
                o_set_cc = 1'b1;
            end
            OP_LDR: begin
                o_imm    = {{10{i_instr[5]}}, i_instr[5:0]};
                o_wr_dst = 1'b1;
                o_set_cc = 1'b1;
            end
            OP_STR: begin
                o_imm = {{10{i_instr[5]}}, i_instr[5:0]};
            end
            OP_BR, OP_ST, OP_STI: begin
                o_imm = {{7{i_instr[8]}}, i_instr[8:0]};
            end
            OP_LEA: begin
                o_imm    = {{7{i_instr[8]}}, i_instr[8:0]};
                o_wr_dst = 1'b1;
            end
            OP_JSR: begin
                // JSRR (instr[11]=0) takes its target from a register.
                if (i_instr[11]) begin
                    o_imm = {{5{i_instr[10]}}, i_instr[10:0]};
                end
                o_dst    = 3'd7;
                o_wr_dst = 1'b1;
            end
            OP_TRAP: begin
                o_imm    = {8'h00, i_instr[7:0]};
                o_dst    = 3'd7;
                o_wr_dst = 1'b1;
            end
            OP_RTI, OP_RES: begin
                o_illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/lc3_operand_fetch.sv
// LC-3 decode/operand-fetch stage: reads the register file, forwards concurrent
// writebacks and hands decoded operands to execute over a valid/ready handshake.
module lc3_operand_fetch
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic [2:0]  rf_sr1,
    output logic [2:0]  rf_sr2,
    input  logic [15:0] rf_sr1_data,
    input  logic [15:0] rf_sr2_data,
    input  logic        wb_en,
    input  logic [2:0]  wb_dst,
    input  logic [15:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [2:0]  out_dst,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_imm,
    output logic        out_use_imm,
    output logic [15:0] out_pc,
    output logic        out_wr_dst,
    output logic        out_set_cc,
    output logic        out_illegal
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_instr;
    logic [15:0] r_pc;
    logic        r_fwd1_vld;
    logic        r_fwd2_vld;
    logic [15:0] r_fwd1_data;
    logic [15:0] r_fwd2_data;

    logic        w_accept;
    logic [15:0] w_src_instr;
    logic [2:0]  w_sr1;
    logic [2:0]  w_sr2;
    logic        w_wb_hit1;
    logic        w_wb_hit2;
    logic [15:0] w_opnd_a;
    logic [15:0] w_opnd_b;

    logic [15:0] w_imm;
    logic [2:0]  w_dst;
    logic        w_wr_dst;
    logic        w_set_cc;
    logic        w_use_imm;
    logic        w_illegal;

    assign in_ready    = !rst && (r_state == StIdle || (r_state == StValid && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_src_instr = w_accept ? in_instr : r_instr;
    assign w_sr1       = src1_of(w_src_instr);
    assign w_sr2       = src2_of(w_src_instr);
    assign rf_sr1      = w_sr1;
    assign rf_sr2      = w_sr2;

    // Matches against whichever instruction currently owns the read ports.
    assign w_wb_hit1 = wb_en && (wb_dst == w_sr1);
    assign w_wb_hit2 = wb_en && (wb_dst == w_sr2);

    // READ-cycle write beats the accept-cycle record, which beats stale RF data.
    assign w_opnd_a = w_wb_hit1 ? wb_data : (r_fwd1_vld ? r_fwd1_data : rf_sr1_data);
    assign w_opnd_b = w_wb_hit2 ? wb_data : (r_fwd2_vld ? r_fwd2_data : rf_sr2_data);

    lc3_imm_decode u_imm_decode (
        .i_instr   (r_instr),
        .o_imm     (w_imm),
        .o_dst     (w_dst),
        .o_wr_dst  (w_wr_dst),
        .o_set_cc  (w_set_cc),
        .o_use_imm (w_use_imm),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StRead;
                end
            end
            StRead: begin
                w_state_next = StValid;
            end
            StValid: begin
                if (out_ready) begin
                    w_state_next = w_accept ? StRead : StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= '0;
            r_pc        <= '0;
            r_fwd1_vld  <= 1'b0;
            r_fwd2_vld  <= 1'b0;
            r_fwd1_data <= '0;
            r_fwd2_data <= '0;
        end else if (w_accept) begin
            r_instr     <= in_instr;
            r_pc        <= in_pc;
            r_fwd1_vld  <= w_wb_hit1;
            r_fwd2_vld  <= w_wb_hit2;
            r_fwd1_data <= wb_data;
            r_fwd2_data <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_dst     <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_imm     <= '0;
            out_use_imm <= 1'b0;
            out_pc      <= '0;
            out_wr_dst  <= 1'b0;
            out_set_cc  <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            case (r_state)
                StRead: begin
                    out_valid   <= 1'b1;
                    out_opcode  <= r_instr[15:12];
                    out_dst     <= w_dst;
                    out_a       <= w_opnd_a;
                    out_b       <= w_opnd_b;
                    out_imm     <= w_imm;
                    out_use_imm <= w_use_imm;
                    out_pc      <= r_pc;
                    out_wr_dst  <= w_wr_dst;
                    out_set_cc  <= w_set_cc;
                    out_illegal <= w_illegal;
                end
                StValid: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end else begin
                        // Keep held operands current with writebacks.
                        if (w_wb_hit1) begin
                            out_a <= wb_data;
                        end
                        if (w_wb_hit2) begin
                            out_b <= wb_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_operand_fetch.sv
// Self-checking bench for lc3_operand_fetch: directed scenarios plus randomized
// traffic against an architectural register-file reference.
module tb_lc3_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic [2:0]  rf_sr1;
    logic [2:0]  rf_sr2;
    logic [15:0] rf_sr1_data;
    logic [15:0] rf_sr2_data;
    logic        wb_en;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [2:0]  out_dst;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_imm;
    logic        out_use_imm;
    logic [15:0] out_pc;
    logic        out_wr_dst;
    logic        out_set_cc;
    logic        out_illegal;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] regs [8];
    logic [15:0] ra, rb, rimm;
    logic [15:0] q_instr [$];
    logic [15:0] q_pc [$];
    logic [15:0] prog [4];
    int          issued, n_out, last_cyc, ready_cyc, n_done;
    logic        exp_valid, exp_ready;

    always #5 clk = ~clk;

    lc3_operand_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rf_sr1      (rf_sr1),
        .rf_sr2      (rf_sr2),
        .rf_sr1_data (rf_sr1_data),
        .rf_sr2_data (rf_sr2_data),
        .wb_en       (wb_en),
        .wb_dst      (wb_dst),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_dst     (out_dst),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_imm     (out_imm),
        .out_use_imm (out_use_imm),
        .out_pc      (out_pc),
        .out_wr_dst  (out_wr_dst),
        .out_set_cc  (out_set_cc),
        .out_illegal (out_illegal)
    );

    // Register file: registered read returns the pre-write value on a collision.
    always @(posedge clk) begin
        rf_sr1_data <= regs[rf_sr1];
        rf_sr2_data <= regs[rf_sr2];
        if (wb_en) regs[wb_dst] <= wb_data;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
        int x;
        x = int'(v) & ((1 << bits) - 1);
        if (x >= (1 << (bits - 1))) x = x - (1 << bits);
        return 16'(x);
    endfunction

    function automatic logic [2:0] ref_sr1(input logic [15:0] i);
        return i[8:6];
    endfunction

    function automatic logic [2:0] ref_sr2(input logic [15:0] i);
        int op;
        op = int'(i[15:12]);
        return (op == 3 || op == 7 || op == 11) ? i[11:9] : i[2:0];
    endfunction

    task automatic check_out(input logic [15:0] instr, input logic [15:0] pc);
        int          op;
        logic [15:0] imm;
        logic [2:0]  dst;
        logic        wr, cc, ui, ill;
        op  = int'(instr[15:12]);
        imm = 16'h0000;
        dst = instr[11:9];
        ui  = 1'b0;
        if (op == 1 || op == 5) begin
            imm = sext(instr, 5);
            ui  = instr[5];
        end
        if (op == 6 || op == 7) imm = sext(instr, 6);
        if (op inside {0, 2, 3, 10, 11, 14}) imm = sext(instr, 9);
        if (op == 4 && instr[11]) imm = sext(instr, 11);
        if (op == 15) imm = {8'h00, instr[7:0]};
        if (op == 4 || op == 15) dst = 3'd7;
        wr  = op inside {1, 2, 4, 5, 6, 9, 10, 14, 15};
        cc  = op inside {1, 2, 5, 6, 9, 10};
        ill = (op == 8 || op == 13);
        chk("opcode", out_opcode, instr[15:12]);
        chk("dst", out_dst, dst);
        chk("a", out_a, regs[ref_sr1(instr)]);
        chk("b", out_b, regs[ref_sr2(instr)]);
        chk("imm", out_imm, imm);
        chk("use_imm", out_use_imm, ui);
        chk("pc", out_pc, pc);
        chk("wr_dst", out_wr_dst, wr);
        chk("set_cc", out_set_cc, cc);
        chk("illegal", out_illegal, ill);
    endtask

    // Entered and left at a negedge with the stage idle; out_ready is held high.
    task automatic run_one(input logic [15:0] instr, input logic [15:0] pc,
                           input logic wa, input logic [2:0] wad, input logic [15:0] wadat,
                           input logic wr, input logic [2:0] wrd, input logic [15:0] wrdat,
                           output logic [15:0] a, output logic [15:0] b,
                           output logic [15:0] imm);
        in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b1;
        wb_en = wa; wb_dst = wad; wb_data = wadat;
        #1;
        chk("acc_sr1", rf_sr1, ref_sr1(instr));
        chk("acc_sr2", rf_sr2, ref_sr2(instr));
        chk("acc_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; wb_en = wr; wb_dst = wrd; wb_data = wrdat;
        #1;
        chk("read_valid", out_valid, 1'b0);
        chk("read_in_ready", in_ready, 1'b0);
        chk("read_sr1", rf_sr1, ref_sr1(instr));
        @(negedge clk);
        wb_en = 1'b0;
        chk("lat_valid", out_valid, 1'b1);
        check_out(instr, pc);
        a = out_a; b = out_b; imm = out_imm;
        @(negedge clk);
        chk("drain_valid", out_valid, 1'b0);
        chk("idle_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; in_pc = 16'h0;
        out_ready = 1'b0; wb_en = 1'b0; wb_dst = 3'd0; wb_data = 16'h0;

        // Reset: preload every register through the write port.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            wb_en = 1'b1; wb_dst = 3'(k);
            wb_data = (k == 1) ? 16'd5 : (k == 2) ? 16'd7 : 16'(16'h0101 * k);
            #1;
            chk("rst_in_ready", in_ready, 1'b0);
        end
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_a", out_a, 16'h0000);
        chk("rst_opcode", out_opcode, 4'h0);
        @(negedge clk);
        wb_en = 1'b0; rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // ADD R3,R1,R2
        run_one(16'h1642, 16'h3001, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, ra, rb, rimm);
        chk("add_a", ra, 16'd5);
        chk("add_b", rb, 16'd7);
        run_one(16'h103F, 16'h3002, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, ra, rb, rimm);
        chk("add_imm_m1", rimm, 16'hFFFF);
        run_one(16'hF025, 16'h3003, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, ra, rb, rimm);
        chk("trap_imm", rimm, 16'h0025);

        // Forwarding: READ-cycle write wins over the accept-cycle record.
        run_one(16'h1642, 16'h3010, 1'b1, 3'd1, 16'h1234, 1'b1, 3'd1, 16'hBEEF, ra, rb, rimm);
        chk("fwd_read_prio", ra, 16'hBEEF);
        run_one(16'h1642, 16'h3011, 1'b1, 3'd1, 16'h1234, 1'b0, 3'd0, 16'h0, ra, rb, rimm);
        chk("fwd_accept_only", ra, 16'h1234);
        run_one(16'h7A83, 16'h3012, 1'b1, 3'd5, 16'h4242, 1'b0, 3'd0, 16'h0, ra, rb, rimm);
        chk("fwd_store_data", rb, 16'h4242);

        // Hold for 5 cycles with a writeback to a held source.
        in_valid = 1'b1; in_instr = 16'h1642; in_pc = 16'h3020; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", out_valid, 1'b1);
            check_out(16'h1642, 16'h3020);
            in_valid = 1'b1; in_instr = 16'h5000;
            wb_en = (k == 1); wb_dst = 3'd2; wb_data = 16'h00AA;
            #1;
            chk("hold_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0; wb_en = 1'b0;
        chk("hold_b_updated", out_b, 16'h00AA);
        chk("hold_still_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", out_valid, 1'b0);

        // Back-to-back stream with random writebacks.
        prog[0] = 16'h1642; prog[1] = 16'h5283; prog[2] = 16'h967F; prog[3] = 16'h6A85;
        issued = 0; n_out = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (out_valid) begin
                if (q_instr.size() == 0) begin
                    chk("stream_spurious", out_valid, 1'b0);
                end else begin
                    check_out(q_instr[0], q_pc[0]);
                    void'(q_instr.pop_front());
                    void'(q_pc.pop_front());
                end
                if (last_cyc >= 0) chk("stream_spacing", 16'(cyc - last_cyc), 16'd2);
                last_cyc = cyc;
                n_out++;
            end
            in_valid = (issued < 4);
            if (issued < 4) in_instr = prog[issued];
            in_pc = 16'(16'h3100 + issued);
            wb_en = 1'($urandom_range(0, 1)); wb_dst = 3'($urandom_range(0, 7));
            wb_data = 16'($urandom());
            #1;
            if (in_valid && in_ready) begin
                q_instr.push_back(in_instr);
                q_pc.push_back(in_pc);
                issued++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; wb_en = 1'b0;
        chk("stream_count", 16'(n_out), 16'd4);
        q_instr.delete(); q_pc.delete();
        @(negedge clk);

        // Random traffic against a latency/occupancy model.
        ready_cyc = 0; n_done = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_instr  = 16'($urandom());
            in_pc     = 16'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_dst    = 3'($urandom_range(0, 7));
            wb_data   = 16'($urandom());
            #1;
            exp_valid = (q_instr.size() != 0) && (cyc >= ready_cyc);
            exp_ready = (q_instr.size() == 0) || (exp_valid && out_ready);
            chk("rnd_valid", out_valid, exp_valid);
            chk("rnd_in_ready", in_ready, exp_ready);
            if (exp_valid && out_valid) begin
                check_out(q_instr[0], q_pc[0]);
                if (out_ready) begin
                    void'(q_instr.pop_front());
                    void'(q_pc.pop_front());
                    n_done++;
                end
            end
            if (in_valid && in_ready) begin
                q_instr.push_back(in_instr);
                q_pc.push_back(in_pc);
                ready_cyc = cyc + 2;
            end
            @(negedge clk);
        end
        chk("rnd_progress", 16'(n_done >= 20), 16'd1);

        // Drain, then reset while an instruction is in READ.
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        q_instr.delete(); q_pc.delete();
        in_valid = 1'b1; in_instr = 16'h1642; in_pc = 16'h3200;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst_read_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_read_valid", out_valid, 1'b0);
        #1;
        chk("rst_read_ready_back", in_ready, 1'b1);
        @(negedge clk);
        chk("rst_dropped", out_valid, 1'b0);
        run_one(16'h1243, 16'h3201, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, ra, rb, rimm);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
